// File: rtl/bexkat1_ifetch_pkg.sv
// Shared definitions for the bexkat1 instruction-fetch stage.
package bexkat1Def;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP,
        S_EXT,
        S_HOLD,
        S_FLUSH
    } ifetch_state_t;

    localparam int          IR_EXT_BIT = 0;
    localparam logic [63:0] IR_BUBBLE  = 64'h0;

endpackage

// File: rtl/bexkat1_ifetch.sv
// bexkat1 instruction fetch: Wishbone reads assembled into a 64-bit IF register.
// Optional bus-error termination and exception flag: define BEXKAT1_IFETCH_BUSERR_EN.
module bexkat1_ifetch
    import bexkat1Def::*;
#(
    parameter int            AW           = 32,
    parameter logic [AW-1:0] RESET_VECTOR = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          stall_i,
    input  logic          pc_set_i,
    input  logic [AW-1:0] pc_target_i,
    output logic          bus_cyc_o,
    output logic          bus_stb_o,
    output logic [AW-1:0] bus_adr_o,
    input  logic [31:0]   bus_dat_i,
    input  logic          bus_ack_i,
`ifdef BEXKAT1_IFETCH_BUSERR_EN
    input  logic          bus_err_i,
    output logic          if_exc,
`endif
    output logic [63:0]   if_ir,
    output logic [AW-1:0] if_pc
);

    localparam logic [AW-1:0] WORD_STEP = AW'(4);
    localparam logic [AW-1:0] ALIGN_MSK = ~AW'(3);

    ifetch_state_t state, state_d;

    logic [AW-1:0] adr_q, adr_d;
    logic [AW-1:0] flush_q, flush_d;
    logic [31:0]   op_word_q, op_word_d;
    logic [AW-1:0] op_pc_q, op_pc_d;
    logic [63:0]   pend_ir_q, pend_ir_d;
    logic [AW-1:0] pend_pc_q, pend_pc_d;
    logic          pend_exc_q, pend_exc_d;
    logic          halt_q, halt_d;
    logic [63:0]   ir_d;
    logic [AW-1:0] pc_d;

    logic          done;
    logic [63:0]   done_ir;
    logic [AW-1:0] done_pc;
    logic          done_exc;

    logic          bus_err;
    logic          term;
    logic          active;
    logic [AW-1:0] target;

`ifdef BEXKAT1_IFETCH_BUSERR_EN
    logic exc_d;
    assign bus_err = bus_err_i;
`else
    assign bus_err = 1'b0;
`endif

    assign term      = bus_ack_i | bus_err;
    assign active    = (state == S_OP) || (state == S_EXT) || (state == S_FLUSH);
    assign target    = pc_target_i & ALIGN_MSK;
    assign bus_cyc_o = active;
    assign bus_stb_o = active;
    assign bus_adr_o = adr_q;

    always_comb begin
        state_d    = state;
        adr_d      = adr_q;
        flush_d    = flush_q;
        op_word_d  = op_word_q;
        op_pc_d    = op_pc_q;
        pend_ir_d  = pend_ir_q;
        pend_pc_d  = pend_pc_q;
        pend_exc_d = pend_exc_q;
        halt_d     = halt_q;
        ir_d       = if_ir;
        pc_d       = if_pc;
`ifdef BEXKAT1_IFETCH_BUSERR_EN
        exc_d      = if_exc;
`endif
        done       = 1'b0;
        done_ir    = IR_BUBBLE;
        done_pc    = adr_q;
        done_exc   = 1'b0;

        case (state)
            S_IDLE: begin
                if (!halt_q)
                    state_d = S_OP;
            end
            S_OP: begin
                if (bus_err) begin
                    done     = 1'b1;
                    done_exc = 1'b1;
                    done_pc  = adr_q;
                end else if (bus_ack_i) begin
                    adr_d = adr_q + WORD_STEP;
                    if (bus_dat_i[IR_EXT_BIT]) begin
                        op_word_d = bus_dat_i;
                        op_pc_d   = adr_q;
                        state_d   = S_EXT;
                    end else begin
                        done    = 1'b1;
                        done_ir = {32'h0, bus_dat_i};
                        done_pc = adr_q;
                    end
                end
            end
            S_EXT: begin
                // Faults during the extension fetch report the opcode's address.
                if (bus_err) begin
                    done     = 1'b1;
                    done_exc = 1'b1;
                    done_pc  = op_pc_q;
                end else if (bus_ack_i) begin
                    adr_d   = adr_q + WORD_STEP;
                    done    = 1'b1;
                    done_ir = {bus_dat_i, op_word_q};
                    done_pc = op_pc_q;
                end
            end
            S_HOLD: begin
                if (!stall_i) begin
                    ir_d    = pend_ir_q;
                    pc_d    = pend_pc_q;
`ifdef BEXKAT1_IFETCH_BUSERR_EN
                    exc_d   = pend_exc_q;
`endif
                    state_d = pend_exc_q ? S_IDLE : S_OP;
                end
            end
            S_FLUSH: begin
                if (term) begin
                    adr_d   = flush_q;
                    state_d = S_OP;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (done) begin
            if (done_exc)
                halt_d = 1'b1;
            if (!stall_i) begin
                ir_d    = done_ir;
                pc_d    = done_pc;
`ifdef BEXKAT1_IFETCH_BUSERR_EN
                exc_d   = done_exc;
`endif
                state_d = done_exc ? S_IDLE : S_OP;
            end else begin
                pend_ir_d  = done_ir;
                pend_pc_d  = done_pc;
                pend_exc_d = done_exc;
                state_d    = S_HOLD;
            end
        end else if (state != S_HOLD && !stall_i) begin
            ir_d = IR_BUBBLE;
`ifdef BEXKAT1_IFETCH_BUSERR_EN
            exc_d = 1'b0;
`endif
        end

        // Redirect beats stall and completion; an unanswered cycle must drain first.
        if (pc_set_i) begin
            ir_d   = IR_BUBBLE;
            halt_d = 1'b0;
`ifdef BEXKAT1_IFETCH_BUSERR_EN
            exc_d  = 1'b0;
`endif
            if (active && !term) begin
                state_d = S_FLUSH;
                flush_d = target;
                adr_d   = adr_q;
            end else begin
                state_d = S_OP;
                adr_d   = target;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            adr_q  <= RESET_VECTOR;
            halt_q <= 1'b0;
            if_ir  <= IR_BUBBLE;
            if_pc  <= RESET_VECTOR;
`ifdef BEXKAT1_IFETCH_BUSERR_EN
            if_exc <= 1'b0;
`endif
        end else begin
            adr_q  <= adr_d;
            halt_q <= halt_d;
            if_ir  <= ir_d;
            if_pc  <= pc_d;
`ifdef BEXKAT1_IFETCH_BUSERR_EN
            if_exc <= exc_d;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        flush_q    <= flush_d;
        op_word_q  <= op_word_d;
        op_pc_q    <= op_pc_d;
        pend_ir_q  <= pend_ir_d;
        pend_pc_q  <= pend_pc_d;
        pend_exc_q <= pend_exc_d;
    end

endmodule

// File: tb/tb_bexkat1_ifetch.sv
// Directed bench for bexkat1_ifetch against a zero-wait instruction memory.
module tb_bexkat1_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        pc_set;
    logic [31:0] pc_target;
    logic        bus_cyc;
    logic        bus_stb;
    logic [31:0] bus_adr;
    logic [31:0] bus_dat;
    logic        bus_ack;
    logic [63:0] if_ir;
    logic [31:0] if_pc;
    logic        ack_en;
`ifdef BEXKAT1_IFETCH_BUSERR_EN
    logic        bus_err = 1'b0;
    logic        if_exc;
`endif

    logic [31:0] mem [0:127];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign bus_ack = bus_cyc & bus_stb & ack_en;
    assign bus_dat = mem[bus_adr[8:2]];

    bexkat1_ifetch #(.AW(32), .RESET_VECTOR(32'h0)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .stall_i     (stall),
        .pc_set_i    (pc_set),
        .pc_target_i (pc_target),
        .bus_cyc_o   (bus_cyc),
        .bus_stb_o   (bus_stb),
        .bus_adr_o   (bus_adr),
        .bus_dat_i   (bus_dat),
        .bus_ack_i   (bus_ack),
`ifdef BEXKAT1_IFETCH_BUSERR_EN
        .bus_err_i   (bus_err),
        .if_exc      (if_exc),
`endif
        .if_ir       (if_ir),
        .if_pc       (if_pc)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[0]   = 32'h1000_0000;
        mem[1]   = 32'h2000_0002;
        mem[2]   = 32'h3000_0004;
        mem[3]   = 32'h4000_0000;
        mem[4]   = 32'h5000_0001;
        mem[5]   = 32'hDEAD_BEEF;
        mem[6]   = 32'h6000_0000;
        mem[7]   = 32'h7000_0000;
        mem[8]   = 32'h8000_0000;
        mem[16]  = 32'hA000_0000;
        mem[64]  = 32'h9000_0000;
        mem[65]  = 32'hC000_0000;
        mem[127] = 32'hB000_0000;

        rst = 1'b1; stall = 1'b0; pc_set = 1'b0; pc_target = 32'h0; ack_en = 1'b1;
        @(negedge clk);
        check("rst_cyc", 64'(bus_cyc), 64'h0);
        check("rst_stb", 64'(bus_stb), 64'h0);
        check("rst_adr", 64'(bus_adr), 64'h0);
        check("rst_ir", if_ir, 64'h0);
        check("rst_pc", 64'(if_pc), 64'h0);
        rst = 1'b0;

        @(negedge clk);  // S_IDLE -> S_OP
        check("start_cyc", 64'(bus_cyc), 64'h1);
        check("start_adr", 64'(bus_adr), 64'h0);
        check("start_ir", if_ir, 64'h0);

        @(negedge clk);
        check("seq0_ir", if_ir, 64'h0000_0000_1000_0000);
        check("seq0_pc", 64'(if_pc), 64'h0);
        @(negedge clk);
        check("seq1_ir", if_ir, 64'h0000_0000_2000_0002);
        check("seq1_pc", 64'(if_pc), 64'h4);
        @(negedge clk);
        check("seq2_ir", if_ir, 64'h0000_0000_3000_0004);
        check("seq2_pc", 64'(if_pc), 64'h8);
        @(negedge clk);
        check("seq3_ir", if_ir, 64'h0000_0000_4000_0000);

        // Two-word instruction at 0x10
        @(negedge clk);
        check("ext_bubble_ir", if_ir, 64'h0);
        check("ext_bubble_pc", 64'(if_pc), 64'hC);
        check("ext_adr", 64'(bus_adr), 64'h14);
        @(negedge clk);
        check("ext_ir", if_ir, 64'hDEAD_BEEF_5000_0001);
        check("ext_pc", 64'(if_pc), 64'h10);
        check("ext_next_adr", 64'(bus_adr), 64'h18);

        // Stall held three cycles while 0x18 completes
        stall = 1'b1;
        @(negedge clk);
        check("hold1_ir", if_ir, 64'hDEAD_BEEF_5000_0001);
        check("hold1_cyc", 64'(bus_cyc), 64'h0);
        check("hold1_adr", 64'(bus_adr), 64'h1C);
        @(negedge clk);
        check("hold2_ir", if_ir, 64'hDEAD_BEEF_5000_0001);
        check("hold2_stb", 64'(bus_stb), 64'h0);
        @(negedge clk);
        check("hold3_ir", if_ir, 64'hDEAD_BEEF_5000_0001);
        check("hold3_pc", 64'(if_pc), 64'h10);
        stall = 1'b0;
        @(negedge clk);
        check("pend_ir", if_ir, 64'h0000_0000_6000_0000);
        check("pend_pc", 64'(if_pc), 64'h18);
        check("resume_cyc", 64'(bus_cyc), 64'h1);
        check("resume_adr", 64'(bus_adr), 64'h1C);
        @(negedge clk);
        check("after_pend_ir", if_ir, 64'h0000_0000_7000_0000);
        check("after_pend_pc", 64'(if_pc), 64'h1C);

        // Redirect to 0x103 while the ack to 0x20 is delayed
        ack_en = 1'b0;
        @(negedge clk);
        check("wait_bubble_ir", if_ir, 64'h0);
        pc_set = 1'b1; pc_target = 32'h0000_0103;
        @(negedge clk);
        pc_set = 1'b0;
        check("flush1_cyc", 64'(bus_cyc), 64'h1);
        check("flush1_adr", 64'(bus_adr), 64'h20);
        check("flush1_ir", if_ir, 64'h0);
        @(negedge clk);
        check("flush2_cyc", 64'(bus_cyc), 64'h1);
        check("flush2_adr", 64'(bus_adr), 64'h20);
        ack_en = 1'b1;
        @(negedge clk);
        check("flush_done_adr", 64'(bus_adr), 64'h100);
        check("flush_stale_ir", if_ir, 64'h0);
        @(negedge clk);
        check("target_ir", if_ir, 64'h0000_0000_9000_0000);
        check("target_pc", 64'(if_pc), 64'h100);

        // Redirect + stall together with a completion at 0x104
        pc_set = 1'b1; stall = 1'b1; pc_target = 32'h0000_0040;
        @(negedge clk);
        pc_set = 1'b0; stall = 1'b0;
        check("combo_ir", if_ir, 64'h0);
        check("combo_adr", 64'(bus_adr), 64'h40);
        check("combo_cyc", 64'(bus_cyc), 64'h1);
        @(negedge clk);
        check("combo_target_ir", if_ir, 64'h0000_0000_A000_0000);
        check("combo_target_pc", 64'(if_pc), 64'h40);

        // Address wrap at the top of memory
        pc_set = 1'b1; pc_target = 32'hFFFF_FFFC;
        @(negedge clk);
        pc_set = 1'b0;
        check("wrap_adr", 64'(bus_adr), 64'hFFFF_FFFC);
        @(negedge clk);
        check("wrap_ir", if_ir, 64'h0000_0000_B000_0000);
        check("wrap_pc", 64'(if_pc), 64'hFFFF_FFFC);
        check("wrap_next_adr", 64'(bus_adr), 64'h0);

        // Asynchronous reset in the middle of an outstanding cycle
        ack_en = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_cyc", 64'(bus_cyc), 64'h0);
        check("arst_adr", 64'(bus_adr), 64'h0);
        check("arst_ir", if_ir, 64'h0);
        check("arst_pc", 64'(if_pc), 64'h0);
        ack_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rerun_adr", 64'(bus_adr), 64'h0);
        check("rerun_cyc", 64'(bus_cyc), 64'h1);
        @(negedge clk);
        check("rerun_ir", if_ir, 64'h0000_0000_1000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
